mem_copy_engine: RTL and testbench

//  Bus initiator for the single-port word memory: reads and writes through its addr/Din/we/re/out interface.

---
 rtl/mem_copy_pkg.sv | 15 +
 rtl/mem_copy_engine.sv | 129 ++++++++++++
 tb/tb_mem_copy_engine.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mem_copy_pkg.sv
// Shared types and default widths for the memory copy engine.
package mem_copy_pkg;

  localparam int unsigned DefAddrW = 32;
  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefLenW  = 9;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StDone
  } state_e;

endpackage

// File: rtl/mem_copy_engine.sv
// Copies len consecutive words from src_addr to dst_addr, one read and one write per word.
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned LEN_W  = DefLenW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  words_copied,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_dout
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  idx_inc;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              we_q, we_d;
  logic              re_q, re_d;

  assign idx_inc = idx_q + LEN_W'(1);

  // Memory strobes and address are computed one cycle ahead and registered, so the
  // memory sees clean flop outputs for the whole cycle.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          src_d = src_addr;
          dst_d = dst_addr;
          len_d = len;
          idx_d = '0;
          cnt_d = '0;
          if (len == '0) begin
            state_d = StDone;
          end else begin
            state_d = StRead;
            re_d    = 1'b1;
            addr_d  = src_addr;
          end
        end
      end
      StRead: begin
        data_d  = mem_dout;
        state_d = StWrite;
        we_d    = 1'b1;
        addr_d  = dst_q + ADDR_W'(idx_q);
      end
      StWrite: begin
        idx_d = idx_inc;
        cnt_d = cnt_q + LEN_W'(1);
        if (idx_inc == len_q) begin
          state_d = StDone;
        end else begin
          state_d = StRead;
          re_d    = 1'b1;
          addr_d  = src_q + ADDR_W'(idx_inc);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      re_q    <= re_d;
    end
  end

  assign busy         = (state_q == StRead) || (state_q == StWrite);
  assign done         = (state_q == StDone);
  assign words_copied = cnt_q;
  assign mem_addr     = addr_q;
  assign mem_din      = data_q;
  assign mem_we       = we_q;
  assign mem_re       = re_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench: behavioural single-port memory plus hand-computed expectations.
module tb_mem_copy_engine;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] src_addr, dst_addr;
  logic [LW-1:0] len;
  logic          busy, done;
  logic [LW-1:0] words_copied;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          mem_we, mem_re;
  logic [DW-1:0] mem_dout;

  logic [DW-1:0] mem [256];
  logic [DW-1:0] dout_hold = '0;
  logic          clr_req = 1'b0;
  int            we_cnt = 0, re_cnt = 0, done_cnt = 0;
  int            n_checks = 0, n_errors = 0;

  always #5 clk = ~clk;

  mem_copy_engine #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .len(len), .busy(busy), .done(done), .words_copied(words_copied),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_re(mem_re),
    .mem_dout(mem_dout)
  );

  // Memory: writes at negedge, read data combinational while re=1, held otherwise.
  always @(negedge clk) begin
    if (clr_req) begin
      for (int i = 0; i < 256; i++) mem[i] = (i < 8) ? DW'(i) : '0;
    end else if (mem_we) begin
      mem[mem_addr[7:0]] = mem_din;
    end
    if (mem_we) we_cnt++;
    if (mem_re) re_cnt++;
    if (done) done_cnt++;
  end

  always @(posedge clk) if (mem_re) dout_hold <= mem[mem_addr[7:0]];
  assign mem_dout = mem_re ? mem[mem_addr[7:0]] : dout_hold;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic init_mem();
    clr_req = 1'b1;
    @(negedge clk);
    #1 clr_req = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at +1 after the start edge, i.e. in cycle 1.
  task automatic do_start(input logic [AW-1:0] s, input logic [AW-1:0] d,
                          input logic [LW-1:0] l);
    src_addr = s;
    dst_addr = d;
    len      = l;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int first_cyc, output int cyc);
    bit found = 1'b0;
    cyc = first_cyc;
    for (int k = 0; k < 200 && !found; k++) begin
      if (done) found = 1'b1;
      else begin
        @(posedge clk);
        #1 cyc++;
      end
    end
    if (!found) cyc = -1;
  endtask

  int cyc, base_we, base_re, base_done;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    len = '0;
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_we_re", {mem_we, mem_re}, 0);
    check_eq("rst_addr_din_wc", {mem_addr, mem_din, words_copied}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Four-word copy with an ignored start pulse in cycle 3, then a back-to-back request.
    init_mem();
    base_done = done_cnt;
    do_start(0, 16, 4);
    check_eq("t1_busy_c1", busy, 1);
    check_eq("t1_re_addr_c1", {mem_re, mem_we, mem_addr}, {2'b10, 32'd0});
    @(posedge clk);
    #1 check_eq("t1_we_addr_c2", {mem_re, mem_we, mem_addr, mem_din}, {2'b01, 32'd16, 32'd0});
    @(posedge clk);
    #1 do_start(0, 40, 4);
    wait_done(4, cyc);
    check_eq("t1_done_cycle", cyc, 9);
    check_eq("t1_wc", words_copied, 4);
    check_eq("t1_busy_done", busy, 0);
    for (int i = 0; i < 4; i++) begin
      check_eq("t1_dst", mem[16 + i], i);
      check_eq("t1_src", mem[i], i);
      check_eq("t4_no_dst40", mem[40 + i], 0);
    end
    @(posedge clk);
    #1 check_eq("t1_wc_hold", words_copied, 4);
    do_start(4, 32, 2);
    check_eq("t4_one_done", done_cnt - base_done, 1);
    wait_done(1, cyc);
    check_eq("t6_done_cycle", cyc, 5);
    check_eq("t6_mem32", mem[32], 4);
    check_eq("t6_mem33", mem[33], 5);
    check_eq("t6_wc", words_copied, 2);

    // Zero-length request.
    @(posedge clk);
    #1 base_we = we_cnt;
    base_re = re_cnt;
    do_start(0, 16, 0);
    wait_done(1, cyc);
    check_eq("t2_done_cycle", cyc, 1);
    check_eq("t2_wc", words_copied, 0);
    repeat (2) @(posedge clk);
    #1 check_eq("t2_no_we_re", {we_cnt - base_we, re_cnt - base_re}, 0);

    // Overlapping forward copy re-reads already written words.
    init_mem();
    do_start(0, 1, 3);
    wait_done(1, cyc);
    check_eq("t3_done_cycle", cyc, 7);
    check_eq("t3_mem0", mem[0], 0);
    check_eq("t3_mem1", mem[1], 0);
    check_eq("t3_mem2", mem[2], 0);
    check_eq("t3_mem3", mem[3], 0);

    // Reset in the write cycle of word 2.
    init_mem();
    base_done = done_cnt;
    do_start(0, 16, 4);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    check_eq("t5_in_write2", {mem_we, mem_addr}, {1'b1, 32'd18});
    rst = 1'b1;
    #1;
    check_eq("t5_we_drop", mem_we, 0);
    check_eq("t5_outs", {busy, done, mem_re, mem_addr, mem_din, words_copied}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("t5_mem17", mem[17], 1);
    check_eq("t5_mem18", mem[18], 0);
    check_eq("t5_mem19", mem[19], 0);
    check_eq("t5_no_done", done_cnt - base_done, 0);
    check_eq("t5_idle", {busy, mem_we, mem_re}, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
